sa_host_sequencer: RTL

Host-side initiator for the 8x8 bit-serial systolic outer-product array. It accepts a stream of (a, b) N-bit vector pairs and applies the per-bit input skew. It drives the array's byte-serial A/B input protocol, flushes the pipeline, and runs the readout sequence. It then captures the N result rows and returns them on a valid/ready result stream. It sits in the FPGA test harness or self-test wrapper, and drives the array's ui_in, uio_in and rst_n pins.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_skew_line.sv | 46 ++++
 rtl/sa_host_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared states and constants for the systolic array host sequencer
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        FLUSH,
        READOUT,
        RESULT
    } sa_state_e;

    // dut_uio bit positions
    localparam int READOUT_BIT = 0;
    localparam int XOR_BIT     = 1;
    localparam int HI_BIT      = 7;

    // Zero beats needed for the last pair to reach PE(N-1,N-1)
    function automatic int flush_beats(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// rtl/sa_skew_line.sv - triangular delay line, bit j delayed j advances
module sa_skew_line #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    assign dout[0] = din[0];

    for (genvar j = 1; j < N; j++) begin : g_bit
        logic [j-1:0] sr_q;
        logic [j-1:0] sr_d;

        if (j == 1) begin : g_one
            always_comb begin
                sr_d = sr_q;
                if (adv) begin
                    sr_d = din[j];
                end
            end
        end else begin : g_many
            always_comb begin
                sr_d = sr_q;
                if (adv) begin
                    sr_d = {sr_q[j-2:0], din[j]};
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sr_q <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end

        // Oldest stage is read before the shift, giving exactly j beats of delay
        assign dout[j] = sr_q[j-1];
    end

endmodule

// File: rtl/sa_host_sequencer.sv
// rtl/sa_host_sequencer.sv - host initiator: skews vector pairs into the array, flushes, reads back rows
module sa_host_sequencer
    import sa_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_last,
    input  logic         in_xor,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_row,
    output logic [2:0]   res_idx,
    output logic         res_last,
    output logic         busy,
    output logic [7:0]   dut_ui,
    output logic [7:0]   dut_uio,
    input  logic [7:0]   dut_uo,
    output logic         dut_rst_n
);

    localparam logic [CW-1:0] FLUSH_INIT = CW'(flush_beats(N));
    localparam logic [CW-1:0] R_LAST     = CW'(N);
    localparam logic [2:0]    IDX_LAST   = 3'(N - 1);

    sa_state_e     state_q, state_d;
    logic          ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] r_q, r_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    ui_q, ui_d;
    logic [7:0]    uio_q, uio_d;
    logic [N-1:0]  bpend_q, bpend_d;
    logic [N-1:0]  rows_q [N];
    logic [N-1:0]  rows_d [N];

    logic          accept;
    logic [N-1:0]  feed_a, feed_b;
    logic [N-1:0]  skew_a, skew_b;
    logic [2:0]    cap_idx;

    assign in_ready = ph_q && (state_q == IDLE || state_q == STREAM);
    assign accept   = in_valid && in_ready;
    assign feed_a   = accept ? in_a : '0;
    assign feed_b   = accept ? in_b : '0;
    assign cap_idx  = 3'(R_LAST - r_q);

    // Skew lines advance on every B edge; unaccepted beats shift in zeros
    sa_skew_line #(.N(N)) u_skew_a (
        .clk   (clk),
        .reset (reset),
        .adv   (ph_q),
        .din   (feed_a),
        .dout  (skew_a)
    );

    sa_skew_line #(.N(N)) u_skew_b (
        .clk   (clk),
        .reset (reset),
        .adv   (ph_q),
        .din   (feed_b),
        .dout  (skew_b)
    );

    always_comb begin
        state_d = state_q;
        ph_d    = (state_q == READOUT) ? 1'b0 : ~ph_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        idx_d   = idx_q;
        uio_d   = uio_q;
        rows_d  = rows_q;
        // B edge presents the A byte; the matching B byte is parked for the next A edge
        ui_d    = ph_q ? 8'(skew_a) : 8'(bpend_q);
        bpend_d = ph_q ? skew_b : bpend_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    uio_d[XOR_BIT] = in_xor;
                    if (in_last) begin
                        cnt_d   = FLUSH_INIT;
                        state_d = FLUSH;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    cnt_d   = FLUSH_INIT;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (ph_q) begin
                    if (cnt_q == CW'(1)) begin
                        cnt_d              = '0;
                        r_d                = '0;
                        uio_d[READOUT_BIT] = 1'b1;
                        state_d            = READOUT;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            READOUT: begin
                // Rows emerge bottom-first; cycle 0 output is stale
                if (r_q != '0) begin
                    rows_d[cap_idx] = dut_uo[N-1:0];
                end
                if (r_q == R_LAST) begin
                    uio_d[READOUT_BIT] = 1'b0;
                    idx_d              = '0;
                    state_d            = RESULT;
                end else begin
                    r_d = r_q + CW'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        uio_d[HI_BIT] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            ui_q    <= '0;
            uio_q   <= '0;
            bpend_q <= '0;
            rows_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            ui_q    <= ui_d;
            uio_q   <= uio_d;
            bpend_q <= bpend_d;
            rows_q  <= rows_d;
        end
    end

    assign res_valid = (state_q == RESULT);
    assign res_row   = rows_q[idx_q];
    assign res_idx   = idx_q;
    assign res_last  = res_valid && (idx_q == IDX_LAST);
    assign busy      = (state_q != IDLE);
    assign dut_ui    = ui_q;
    assign dut_uio   = uio_q;
    assign dut_rst_n = ~reset;

endmodule
